// File: rtl/mem_arbiter.sv
// Arbiter for the single RAM port shared by the icache and dcache.
// The dcache has priority; a streak counter bounds icache starvation and dlock keeps block transfers atomic.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    input  logic              dlock,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [1:0] RS_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          dreq;
    logic          access;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == RS_ACCESS);

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                // Forced icache grant once the dcache has won MAX_STREAK times in a row.
                if (dreq && iREN && streak_q == STREAK_MAX) begin
                    state_d  = IGRANT;
                    streak_d = '0;
                end else if (dreq) begin
                    state_d = DGRANT;
                    if (!iREN)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 1'b1;
                end else if (iREN) begin
                    state_d  = IGRANT;
                    streak_d = '0;
                end
            end
            DGRANT: begin
                // Under dlock the bus is kept, whether a word just finished or the cache is idle between words.
                if (!dreq || access)
                    state_d = dlock ? DGRANT : IDLE;
            end
            IGRANT: begin
                if (!iREN || access)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        if (nRST) begin
            case (state_q)
                DGRANT: begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dwait    = ~access;
                    dload    = access ? ramload : '0;
                end
                IGRANT: begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    iwait   = ~access;
                    iload   = access ? ramload : '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against an ownership/streak reference model.
module tb_mem_arbiter;
    localparam int MAXS = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    localparam logic [131:0] IDLE_OUT = {1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, dlock;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the port (0 none, 1 dcache, 2 icache) and the dcache win streak.
    int m_own    = 0;
    int m_streak = 0;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dlock(dlock),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!nRST) begin
            m_own    <= 0;
            m_streak <= 0;
        end else if (m_own == 0) begin
            if ((dREN || dWEN) && iREN && m_streak == MAXS) begin
                m_own <= 2; m_streak <= 0;
            end else if (dREN || dWEN) begin
                m_own    <= 1;
                m_streak <= iREN ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
            end else if (iREN) begin
                m_own <= 2; m_streak <= 0;
            end
        end else if (m_own == 1) begin
            if (!(dREN || dWEN) || ramstate == ACCESS) m_own <= dlock ? 1 : 0;
        end else begin
            if (!iREN || ramstate == ACCESS) m_own <= 0;
        end
    end

    function automatic logic [131:0] model_out();
        logic acc;
        acc = (ramstate == ACCESS);
        if (!nRST || m_own == 0) return IDLE_OUT;
        if (m_own == 1)
            return {1'b1, 32'h0, !acc, acc ? ramload : 32'h0,
                    dREN && !dWEN, dWEN, daddr, dstore};
        return {!acc, acc ? ramload : 32'h0, 1'b1, 32'h0, iREN, 1'b0, iaddr, 32'h0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0; dlock = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    endtask

    task automatic test_reset();
        logic [131:0] got;
        nRST = 0; iREN = 1; dREN = 1; dWEN = 1; daddr = 32'h1234; dstore = 32'h55;
        ramstate = ACCESS; ramload = 32'hFFFF_0000;
        tick(); tick(); #1;
        got = {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore};
        checks++;
        if (got !== IDLE_OUT) begin
            failures++; $display("FAIL reset_outputs got=%h want=%h", got, IDLE_OUT);
        end
        clear_inputs(); nRST = 1;
        tick(); #1;
        got = {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore};
        checks++;
        if (got !== IDLE_OUT) begin
            failures++; $display("FAIL idle_after_reset got=%h want=%h", got, IDLE_OUT);
        end
    endtask

    task automatic test_icache_read();
        iREN = 1; iaddr = 32'h40; #1;
        checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            failures++; $display("FAIL icache_latency ramREN=%b iwait=%b want 0/1", ramREN, iwait);
        end
        tick(); ramstate = BUSY; #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
            failures++; $display("FAIL icache_grant ramREN=%b ramaddr=%h iwait=%b want 1/40/1", ramREN, ramaddr, iwait);
        end
        tick(); ramstate = ACCESS; ramload = 32'h2408_0001; #1;
        checks++;
        if (iwait !== 1'b0 || iload !== 32'h2408_0001 || dwait !== 1'b1) begin
            failures++; $display("FAIL icache_complete iwait=%b iload=%h want 0/24080001", iwait, iload);
        end
        tick(); iREN = 0; ramstate = FREE; #1;
        checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            failures++; $display("FAIL icache_back_idle ramREN=%b iwait=%b want 0/1", ramREN, iwait);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; ramstate = FREE;
        tick(); ramstate = ACCESS; ramload = 32'hA5A5_0100; #1;
        checks++;
        if ({ramREN, ramWEN, ramaddr, dwait, dload, iwait} !== {1'b1, 1'b0, 32'h100, 1'b0, 32'hA5A5_0100, 1'b1}) begin
            failures++; $display("FAIL dcache_first ramREN=%b ramaddr=%h dwait=%b dload=%h iwait=%b", ramREN, ramaddr, dwait, dload, iwait);
        end
        tick(); dREN = 0; ramstate = FREE; #1;
        checks++;
        if ({ramREN, iwait, dwait} !== 3'b011) begin
            failures++; $display("FAIL gap_cycle ramREN=%b iwait=%b dwait=%b want 0/1/1", ramREN, iwait, dwait);
        end
        tick(); ramstate = ACCESS; ramload = 32'h11; #1;
        checks++;
        if ({ramREN, ramaddr, iwait, iload, dwait} !== {1'b1, 32'h44, 1'b0, 32'h11, 1'b1}) begin
            failures++; $display("FAIL icache_second ramREN=%b ramaddr=%h iwait=%b iload=%h", ramREN, ramaddr, iwait, iload);
        end
        tick(); clear_inputs(); tick();
    endtask

    task automatic test_dlock();
        dWEN = 1; dlock = 1; daddr = 32'h200; dstore = 32'hAAAA_0001; iREN = 1; iaddr = 32'h80;
        tick(); ramstate = ACCESS; #1;
        checks++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dwait} !== {1'b1, 1'b0, 32'h200, 32'hAAAA_0001, 1'b0}) begin
            failures++; $display("FAIL lock_word0 ramWEN=%b ramaddr=%h ramstore=%h dwait=%b", ramWEN, ramaddr, ramstore, dwait);
        end
        tick(); daddr = 32'h204; dstore = 32'hAAAA_0002; #1;
        checks++;
        if ({ramWEN, ramaddr, ramstore, dwait} !== {1'b1, 32'h204, 32'hAAAA_0002, 1'b0}) begin
            failures++; $display("FAIL lock_word1 ramWEN=%b ramaddr=%h ramstore=%h dwait=%b", ramWEN, ramaddr, ramstore, dwait);
        end
        tick(); dWEN = 0; ramstate = FREE; #1;
        checks++;
        if ({ramWEN, ramREN, iwait} !== 3'b001) begin
            failures++; $display("FAIL lock_hold ramWEN=%b ramREN=%b iwait=%b want 0/0/1", ramWEN, ramREN, iwait);
        end
        tick(); dlock = 0; #1;
        checks++;
        if ({ramWEN, ramREN} !== 2'b00) begin
            failures++; $display("FAIL lock_release ramWEN=%b ramREN=%b want 0/0", ramWEN, ramREN);
        end
        tick(); #1;
        checks++;
        if (ramREN !== 1'b0) begin
            failures++; $display("FAIL lock_idle ramREN=%b want 0", ramREN);
        end
        tick(); ramstate = ACCESS; ramload = 32'h77; #1;
        checks++;
        if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h80, 1'b0}) begin
            failures++; $display("FAIL lock_then_icache ramREN=%b ramaddr=%h iwait=%b want 1/80/0", ramREN, ramaddr, iwait);
        end
        tick(); clear_inputs(); tick();
    endtask

    task automatic test_starvation();
        logic [31:0] want;
        iREN = 1; iaddr = 32'hC0; dREN = 1;
        for (int k = 1; k <= 5; k++) begin
            daddr = 32'h1000 + 32'(k * 4); ramstate = FREE;
            tick(); ramstate = ACCESS; ramload = 32'(k); #1;
            want = (k <= MAXS) ? daddr : iaddr;
            checks++;
            if (ramaddr !== want || ramREN !== 1'b1 || iwait !== (k <= MAXS)) begin
                failures++; $display("FAIL starve_grant%0d ramaddr=%h want=%h iwait=%b", k, ramaddr, want, iwait);
            end
            tick();
        end
        clear_inputs(); tick();
    endtask

    task automatic test_write_wins_error();
        dWEN = 1; dREN = 1; dstore = 32'hDEAD_BEEF; daddr = 32'h3100;
        tick(); ramstate = ERROR; #1;
        checks++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dwait} !== {1'b1, 1'b0, 32'h3100, 32'hDEAD_BEEF, 1'b1}) begin
            failures++; $display("FAIL write_wins ramWEN=%b ramREN=%b ramaddr=%h ramstore=%h dwait=%b", ramWEN, ramREN, ramaddr, ramstore, dwait);
        end
        tick(); #1;
        checks++;
        if ({ramWEN, dwait} !== 2'b11) begin
            failures++; $display("FAIL error_retry ramWEN=%b dwait=%b want 1/1", ramWEN, dwait);
        end
        tick(); ramstate = ACCESS; #1;
        checks++;
        if ({ramWEN, dwait} !== 2'b10) begin
            failures++; $display("FAIL error_then_access ramWEN=%b dwait=%b want 1/0", ramWEN, dwait);
        end
        tick(); clear_inputs(); tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] want;
        dWEN = 1; daddr = 32'h400; dstore = 32'h1; iREN = 1; iaddr = 32'h48; ramstate = BUSY;
        tick(); #1;
        checks++;
        if ({ramWEN, ramaddr} !== {1'b1, 32'h400}) begin
            failures++; $display("FAIL pre_reset_grant ramWEN=%b ramaddr=%h want 1/400", ramWEN, ramaddr);
        end
        nRST = 0;
        tick(); #1;
        checks++;
        if ({ramWEN, ramREN, dwait, iwait} !== 4'b0011) begin
            failures++; $display("FAIL reset_abort ramWEN=%b ramREN=%b dwait=%b iwait=%b", ramWEN, ramREN, dwait, iwait);
        end
        // A cleared streak gives the dcache a full MAX_STREAK run again.
        nRST = 1; dWEN = 0; dREN = 1;
        for (int k = 1; k <= 5; k++) begin
            daddr = 32'h500 + 32'(k * 4); ramstate = FREE;
            tick(); ramstate = ACCESS; #1;
            want = (k <= MAXS) ? daddr : iaddr;
            checks++;
            if (ramaddr !== want) begin
                failures++; $display("FAIL streak_cleared%0d ramaddr=%h want=%h", k, ramaddr, want);
            end
            tick();
        end
        clear_inputs(); tick();
    endtask

    task automatic test_random();
        logic [131:0] got, want;
        for (int n = 0; n < 1500; n++) begin
            nRST     = ($urandom_range(0, 63) != 0);
            iREN     = ($urandom_range(0, 1) == 1);
            dREN     = ($urandom_range(0, 9) < 4);
            dWEN     = ($urandom_range(0, 9) < 3);
            dlock    = ($urandom_range(0, 3) == 0);
            iaddr    = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            #1;
            got  = {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore};
            want = model_out();
            checks++;
            if (got !== want) begin
                failures++; $display("FAIL random_cycle%0d got=%h want=%h", n, got, want);
            end
            tick();
        end
        nRST = 1; clear_inputs(); tick();
    endtask

    initial begin
        clear_inputs();
        nRST = 0;
        @(negedge CLK);
        test_reset();
        test_icache_read();
        test_same_cycle();
        test_dlock();
        test_starvation();
        test_write_wins_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single RAM port between the icache and the dcache.
- Sits between the two caches' memory-side request signals and the RAM model.
- Registered owner FSM; the dcache has priority.
- A dcache lock keeps a two-word block writeback or fill atomic.
- A streak counter bounds icache starvation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_STREAK, 4, consecutive dcache grants allowed while iREN is pending before the icache is forced a grant.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset; the block has one clock, and reset is synchronous and active-low
- iREN  input  1  icache read request
- iaddr  input  ADDR_W  icache address
- iwait  output  1  icache wait; 0 only in the cycle its access completes
- iload  output  DATA_W  icache read data
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request
- daddr  input  ADDR_W  dcache address
- dstore  input  DATA_W  dcache write data
- dlock  input  1  dcache holds the bus across consecutive accesses (block transfer or flush)
- dwait  output  1  dcache wait
- dload  output  DATA_W  dcache read data
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  DATA_W  RAM write data
- ramload  input  DATA_W  RAM read data
- ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- FSM states: IDLE, DGRANT, IGRANT. The state register and streak counter (width clog2(MAX_STREAK+1)) are the only storage.
- Reset: state=IDLE and streak=0 at the rising edge with nRST=0. With nRST low, or in IDLE:
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0
  - iwait=dwait=1, iload=dload=0
- Reset mid-transaction aborts the transaction with no completion; the requester re-issues.
- IDLE arbitration (decision registered; the RAM is driven from the next cycle, so one cycle of grant latency):
  - dreq=dREN|dWEN.
  - If dreq and iREN and streak==MAX_STREAK: go to IGRANT.
  - Else if dreq: go to DGRANT.
  - Else if iREN: go to IGRANT.
  - Else stay in IDLE.
- DGRANT:
  - ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both are set).
  - ramaddr=daddr, ramstore=dstore.
  - dwait=~(ramstate==ACCESS); dload=ramload when ramstate==ACCESS, else 0.
- IGRANT:
  - ramREN=iREN, ramaddr=iaddr, ramstore=0.
  - iwait=~(ramstate==ACCESS); iload=ramload when ramstate==ACCESS, else 0.
- The non-owner sees wait=1 and load=0.
- Completion (owner request high and ramstate==ACCESS):
  - DGRANT with dlock=1: stay in DGRANT for the next word.
  - Otherwise: go to IDLE.
- BUSY, FREE or ERROR in a granted state: hold state and hold RAM signals (ERROR is treated as a retry, never as completion).
- Owner drops its request before completion: go to IDLE next cycle; no wait pulse is issued.
- Owner in DGRANT with dlock=1 and no request: stay in DGRANT, RAM enables 0.
- dlock is ignored in IGRANT and IDLE.
- Streak counter updates on each transition into a grant:
  - Entering DGRANT with iREN=1: streak+1, saturating at MAX_STREAK.
  - Entering DGRANT with iREN=0: streak=0.
  - Entering IGRANT: streak=0.
  - Staying in DGRANT under dlock does not count as a new grant.
- Simultaneous completion and new requests: the new request is arbitrated only from IDLE, so back-to-back accesses from different owners have a minimum gap of one IDLE cycle.

Test Plan:
- Reset, then iREN=1, iaddr=0x0000_0040, ramstate=ACCESS one cycle after grant, ramload=0x2408_0001:
  - cycle 1: IGRANT, ramREN=1, ramaddr=0x40
  - completion cycle: iwait=0, iload=0x2408_0001
  - following cycle: IDLE.
- Same-cycle request, iREN=1 and dREN=1 daddr=0x100:
  - dcache granted first; dwait=0 on ACCESS; iwait stays 1.
  - icache granted after one IDLE cycle.
- dlock=1 with dWEN, daddr=0x200 then 0x204, iREN held high:
  - both writes complete in consecutive DGRANT words with no IDLE between them.
  - icache granted only after dlock=0.
- Starvation, MAX_STREAK=4: iREN held high with 5 back-to-back unlocked dcache reads.
  - grants 1-4 go to dcache.
  - the 5th arbitration goes to IGRANT even though dREN=1.
- dWEN=1 and dREN=1 together, dstore=0xDEAD_BEEF, daddr=0x3100:
  - ramWEN=1, ramREN=0, ramstore=0xDEAD_BEEF.
  - ramstate=ERROR for 2 cycles keeps dwait=1; dwait=0 on the first ACCESS cycle.
- nRST=0 asserted mid-DGRANT with ramstate=BUSY:
  - at the next edge, ramWEN=ramREN=0 and dwait=1.
  - streak=0 and state IDLE.
